alp_muldiv_seq: RTL

- Multi-cycle step sequencer for the ALP data-path slice. Drives the slice's ALU function inputs (alu_h, bcd_op_l, pass_a_h) once per cycle for unsigned shift-and-add multiply and non-restoring divide.
- It is the encoding side of the ALU control interface. It turns one start request into a timed string of ADD_SR/SUB_SL/ADD_SL/ADD function codes, steered by status fed back from the slice.
- It sits between the microsequencer's start/op fields and the ALP ALU control decode.

---
 rtl/alp_pkg.sv | 36 +++
 rtl/alp_muldiv_opsel.sv | 75 +++++++
 rtl/alp_muldiv_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alp_pkg.sv
// ---------------------------------------------------------------------------
// alp_pkg
// Shared definitions for the ALP data-path slice control logic.
//   - ALU function codes driven on alu_h.
//   - Step sequencer state encoding.
// ---------------------------------------------------------------------------
package alp_pkg;

    // ALU function codes
    localparam logic [3:0] ALU_SUB     = 4'b0000;
    localparam logic [3:0] ALU_SUB_BCD = 4'b0001;
    localparam logic [3:0] ALU_SUB_SR  = 4'b0010;
    localparam logic [3:0] ALU_SUB_SL  = 4'b0011;
    localparam logic [3:0] ALU_ADD     = 4'b0100;
    localparam logic [3:0] ALU_ADD_BCD = 4'b0101;
    localparam logic [3:0] ALU_ADD_SR  = 4'b0110;
    localparam logic [3:0] ALU_ADD_SL  = 4'b0111;
    localparam logic [3:0] ALU_AND     = 4'b1000;
    localparam logic [3:0] ALU_OR      = 4'b1001;
    localparam logic [3:0] ALU_AND_SR  = 4'b1010;
    localparam logic [3:0] ALU_AND_SL  = 4'b1011;
    localparam logic [3:0] ALU_SUB_BA  = 4'b1100;
    localparam logic [3:0] ALU_XOR     = 4'b1101;
    localparam logic [3:0] ALU_ANDNOT  = 4'b1110;
    localparam logic [3:0] ALU_NOTAND  = 4'b1111;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MSTEP = 3'd1,
        ST_DSTEP = 3'd2,
        ST_DFIX  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/alp_muldiv_opsel.sv
// ---------------------------------------------------------------------------
// alp_muldiv_opsel
// Combinational decode of sequencer state, step count and slice status into
// the per-cycle ALU control word. Stall gating is applied by the parent.
// Ports:
//   state       in   current sequencer state
//   cnt         in   current step index
//   q_lsb_h     in   multiplier bit in Q LSB (selects add / skip)
//   alu_sign_h  in   sign of previous ALU result (steers add/sub in divide)
//   alu_h       out  ALU function code
//   pass_a_h    out  pass-A qualifier
//   b_zero_h    out  zero the B operand
//   q_shift_h   out  shift Q this cycle
//   q_bit_h     out  bit shifted into Q
// ---------------------------------------------------------------------------
module alp_muldiv_opsel
    import alp_pkg::*;
#(
    parameter int CW = 6
) (
    input  state_e          state,
    input  logic [CW-1:0]   cnt,
    input  logic            q_lsb_h,
    input  logic            alu_sign_h,
    output logic [3:0]      alu_h,
    output logic            pass_a_h,
    output logic            b_zero_h,
    output logic            q_shift_h,
    output logic            q_bit_h
);

    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // case below can leave a value unassigned and infer a latch.
        alu_h     = ALU_OR;
        pass_a_h  = 1'b1;
        b_zero_h  = 1'b0;
        q_shift_h = 1'b0;
        q_bit_h   = 1'b0;

        case (state)
            ST_MSTEP: begin
                // Shift-and-add: add B only when the multiplier bit is 1.
                alu_h     = ALU_ADD_SR;
                pass_a_h  = 1'b0;
                b_zero_h  = ~q_lsb_h;
                q_shift_h = 1'b1;
            end
            ST_DSTEP: begin
                pass_a_h = 1'b0;
                if (cnt == '0) begin
                    // First step always subtracts; no quotient bit exists yet.
                    alu_h = ALU_SUB_SL;
                end else begin
                    // Non-restoring: a negative partial remainder is added back
                    // on the next step instead of being restored.
                    alu_h     = alu_sign_h ? ALU_ADD_SL : ALU_SUB_SL;
                    q_shift_h = 1'b1;
                    q_bit_h   = ~alu_sign_h;
                end
            end
            ST_DFIX: begin
                // Final quotient bit, plus remainder restore if it went negative.
                q_shift_h = 1'b1;
                q_bit_h   = ~alu_sign_h;
                if (alu_sign_h) begin
                    alu_h    = ALU_ADD;
                    pass_a_h = 1'b0;
                end
            end
            default: ; // IDLE and DONE pass A unchanged
        endcase
    end

endmodule

// File: rtl/alp_muldiv_seq.sv
// ---------------------------------------------------------------------------
// alp_muldiv_seq
// Multi-cycle step sequencer for unsigned shift-and-add multiply and
// non-restoring divide on the ALP data-path slice.
// Ports:
//   clk_h       in   clock, rising edge
//   reset_h     in   asynchronous active-high reset
//   start_h     in   start request (sampled in IDLE only)
//   op_div_h    in   0 = multiply, 1 = divide (sampled with start_h)
//   stall_h     in   freeze the sequencer this cycle
//   abort_h     in   abandon operation, return to IDLE
//   q_lsb_h     in   multiplier bit in Q LSB
//   alu_sign_h  in   sign of previous ALU result
//   alu_h       out  ALU function code
//   bcd_op_l    out  BCD select (active low, tied inactive)
//   pass_a_h    out  pass-A qualifier
//   b_zero_h    out  zero the B operand
//   q_shift_h   out  shift Q this cycle
//   q_bit_h     out  bit shifted into Q
//   busy_h      out  operation in progress
//   done_h      out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module alp_muldiv_seq
    import alp_pkg::*;
#(
    parameter int STEPS = 32,
    parameter int CW    = 6
) (
    input  logic        clk_h,
    input  logic        reset_h,
    input  logic        start_h,
    input  logic        op_div_h,
    input  logic        stall_h,
    input  logic        abort_h,
    input  logic        q_lsb_h,
    input  logic        alu_sign_h,
    output logic [3:0]  alu_h,
    output logic        bcd_op_l,
    output logic        pass_a_h,
    output logic        b_zero_h,
    output logic        q_shift_h,
    output logic        q_bit_h,
    output logic        busy_h,
    output logic        done_h
);

    state_e          state;
    logic [CW-1:0]   cnt;
    logic [3:0]      alu_hold;
    logic            pass_hold;

    logic [3:0]      dec_alu;
    logic            dec_pass;
    logic            dec_shift;
    logic            stalled;
    logic            last_step;

    alp_muldiv_opsel #(.CW(CW)) u_opsel (
        .state      (state),
        .cnt        (cnt),
        .q_lsb_h    (q_lsb_h),
        .alu_sign_h (alu_sign_h),
        .alu_h      (dec_alu),
        .pass_a_h   (dec_pass),
        .b_zero_h   (b_zero_h),
        .q_shift_h  (dec_shift),
        .q_bit_h    (q_bit_h)
    );

    assign stalled   = stall_h && (state != ST_IDLE);
    assign last_step = (cnt == CW'(STEPS - 1));

    // A stalled cycle repeats the previous function so the slice sees a
    // stable control word; Q must not move while frozen.
    assign alu_h     = stalled ? alu_hold  : dec_alu;
    assign pass_a_h  = stalled ? pass_hold : dec_pass;
    assign q_shift_h = dec_shift & ~stalled;
    assign bcd_op_l  = 1'b1;
    assign busy_h    = (state != ST_IDLE);
    assign done_h    = (state == ST_DONE) && !stall_h;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_h or posedge reset_h) begin
        if (reset_h) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            alu_hold  <= ALU_OR;
            pass_hold <= 1'b1;
        end else begin
            alu_hold  <= alu_h;
            pass_hold <= pass_a_h;

            if (abort_h) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_h) begin
                            state <= op_div_h ? ST_DSTEP : ST_MSTEP;
                            cnt   <= '0;
                        end
                    end
                    ST_MSTEP: begin
                        if (!stall_h) begin
                            if (last_step) begin
                                state <= ST_DONE;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    ST_DSTEP: begin
                        if (!stall_h) begin
                            if (last_step) begin
                                state <= ST_DFIX;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    ST_DFIX: begin
                        if (!stall_h) state <= ST_DONE;
                    end
                    ST_DONE: begin
                        if (!stall_h) state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
